// File: rtl/irq_encoder8t3_pkg.sv
// Shared definitions for the 8-source interrupt encoder.
// Contents: FSM state encoding, source count, ID width and mask reset value.
// Latency: n/a (definitions only).  Backpressure: n/a.
package irq_encoder8t3_pkg;

   localparam int N_IRQ = 8;
   localparam int IRQ_ID_W = 3;

   // Mask comes out of reset fully closed so no source can interrupt the CPU
   // before software has configured it.
   localparam logic [N_IRQ-1:0] MASK_RST = 8'hFF;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } irq_state_t;

endpackage

// File: rtl/irq_encoder8t3_rr_prio_enc8.sv
// Rotating priority encoder: first set bit of req searching ptr, ptr+1, ..., ptr-1.
// Ports: req[7:0] candidates, ptr[2:0] start position; any = some bit set, idx = winner.
// Latency: purely combinational.  Backpressure: none.
module rr_prio_enc8
   import irq_encoder8t3_pkg::*;
(
   input  logic [N_IRQ-1:0]    req,
   input  logic [IRQ_ID_W-1:0] ptr,
   output logic                any,
   output logic [IRQ_ID_W-1:0] idx
);

   logic [2*N_IRQ-1:0]  req_dbl;
   logic [N_IRQ-1:0]    rot;
   logic [IRQ_ID_W-1:0] ffs;

   // Rotating right by ptr moves bit ptr to position 0, so a plain
   // lowest-set-bit search on rot realises the circular search order.
   assign req_dbl = {req, req} >> ptr;
   assign rot     = req_dbl[N_IRQ-1:0];
   assign any     = |req;

   always_comb begin
      ffs = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            ffs = IRQ_ID_W'(i);
         end
      end
   end

   // Undo the rotation; the 3-bit add wraps modulo 8 by construction.
   assign idx = ffs + ptr;

endmodule

// File: rtl/irq_encoder8t3.sv
// Interrupt encoder: latches rising edges on 8 request lines, masks them, and
// presents one winner (round-robin or fixed priority) to the CPU as irq_req/irq_id.
// Ports: clk, rst (async, active high); irq_in raw lines; mask_we/mask_wdata mask
// write, mask readback; pending latched events; irq_req/irq_id to CPU; irq_ack from CPU.
// Latency: edge sampled at cycle n -> pending at n+1 -> irq_req/irq_id at n+2.
// Backpressure: a presented request is held stable until irq_ack; further
// events accumulate in pending and are presented after at least one idle cycle.
module irq_encoder8t3
   import irq_encoder8t3_pkg::*;
#(
   parameter int N_SRC = 8,   // fixed at 8 in this revision
   parameter int ID_W  = 3,   // must equal clog2(N_SRC)
   parameter int RR_EN = 1    // 1 = round-robin, 0 = fixed priority with bit 0 highest
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic [N_SRC-1:0] mask,
   output logic [N_SRC-1:0] pending,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack
);

   irq_state_t       state;
   irq_state_t       state_nxt;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] clr;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  enc_ptr;
   logic [ID_W-1:0]  win_idx;
   logic             win_any;
   logic             id_load;
   logic             ack_fire;

   assign rise     = irq_in & ~irq_q;
   assign eligible = pending & ~mask;

   // Fixed priority is just the rotating search pinned at bit 0.
   assign enc_ptr  = (RR_EN != 0) ? ptr : '0;

   rr_prio_enc8 u_enc (
      .req (eligible),
      .ptr (enc_ptr),
      .any (win_any),
      .idx (win_idx)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_any) state_nxt = REQ;
         REQ:     if (irq_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // irq_req is a decode of the state register, so it is registered and has
   // no combinational path from irq_ack.
   always_comb begin
      irq_req  = (state == REQ);
      id_load  = (state == IDLE) && win_any;
      ack_fire = (state == REQ) && irq_ack;
   end

   assign clr = ack_fire ? (N_SRC'(1) << irq_id) : '0;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q   <= '0;
         pending <= '0;
         mask    <= MASK_RST;
         ptr     <= '0;
         irq_id  <= '0;
      end else begin
         irq_q <= irq_in;
         // Set is applied after clear so a new edge on the acked source wins.
         pending <= (pending & ~clr) | rise;
         if (mask_we) begin
            mask <= mask_wdata;
         end
         if (id_load) begin
            irq_id <= win_idx;
         end
         if (ack_fire && (RR_EN != 0)) begin
            ptr <= irq_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_irq_encoder8t3.sv
// Bench for irq_encoder8t3: two instances (round-robin and fixed priority)
// driven with shared stimulus; directed scenarios followed by random traffic,
// every cycle compared against a behavioural model.
module tb_irq_encoder8t3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       irq_ack;

   logic [7:0] mask_r, pend_r, mask_f, pend_f;
   logic       req_r, req_f;
   logic [2:0] id_r, id_f;

   int nchk  = 0;
   int npass = 0;
   int nfail = 0;

   // model state: index 0 = round-robin instance, 1 = fixed priority instance
   logic [7:0] m_q;
   logic [7:0] m_mask;
   logic [7:0] m_pend [2];
   logic       m_req  [2];
   int         m_id   [2];
   int         m_ptr  [2];

   always #5 clk = ~clk;

   irq_encoder8t3 #(.N_SRC(8), .ID_W(3), .RR_EN(1)) u_rr (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask_r), .pending(pend_r), .irq_req(req_r), .irq_id(id_r), .irq_ack(irq_ack)
   );

   irq_encoder8t3 #(.N_SRC(8), .ID_W(3), .RR_EN(0)) u_fx (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask_f), .pending(pend_f), .irq_req(req_f), .irq_id(id_f), .irq_ack(irq_ack)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q    = 8'h00;
      m_mask = 8'hFF;
      for (int j = 0; j < 2; j++) begin
         m_pend[j] = 8'h00;
         m_req[j]  = 1'b0;
         m_id[j]   = 0;
         m_ptr[j]  = 0;
      end
   endtask

   // One clock of the specified behaviour, using the pre-edge inputs.
   task automatic model_step();
      logic [7:0] rise, p, el;
      int base;
      rise = irq_in & ~m_q;
      for (int j = 0; j < 2; j++) begin
         p = m_pend[j];
         if (m_req[j]) begin
            if (irq_ack) begin
               p[m_id[j]] = 1'b0;
               m_req[j] = 1'b0;
               if (j == 0) m_ptr[0] = (m_id[0] + 1) % 8;
            end
         end else begin
            el   = m_pend[j] & ~m_mask;
            base = (j == 0) ? m_ptr[0] : 0;
            for (int k = 0; k < 8; k++) begin
               if (!m_req[j] && el[(base + k) % 8]) begin
                  m_req[j] = 1'b1;
                  m_id[j]  = (base + k) % 8;
               end
            end
         end
         m_pend[j] = p | rise;
      end
      if (mask_we) m_mask = mask_wdata;
      m_q = irq_in;
   endtask

   task automatic cmp_model();
      chk("rr_pending", pend_r, m_pend[0]);
      chk("rr_req", 8'(req_r), 8'(m_req[0]));
      chk("rr_id", 8'(id_r), 8'(m_id[0]));
      chk("rr_mask", mask_r, m_mask);
      chk("fx_pending", pend_f, m_pend[1]);
      chk("fx_req", 8'(req_f), 8'(m_req[1]));
      chk("fx_id", 8'(id_f), 8'(m_id[1]));
      chk("fx_mask", mask_f, m_mask);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cmp_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_we    = 1'b1;
      mask_wdata = v;
      tick();
      mask_we    = 1'b0;
   endtask

   task automatic ack_once();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      irq_in     = 8'h00;
      mask_we    = 1'b0;
      mask_wdata = 8'h00;
      irq_ack    = 1'b0;
      model_reset();
      #3;
      chk("reset_mask", mask_r, 8'hFF);
      chk("reset_pending", pend_r, 8'h00);
      chk("reset_req", 8'(req_r), 8'h00);
      chk("reset_id", 8'(id_r), 8'h00);
      rst = 1'b0;

      // single event on source 5
      write_mask(8'h00);
      irq_in = 8'h20;
      tick();
      chk("single_pending_n1", pend_r, 8'h20);
      chk("single_req_n1", 8'(req_r), 8'h00);
      irq_in = 8'h00;
      tick();
      chk("single_req_n2", 8'(req_r), 8'h01);
      chk("single_id_n2", 8'(id_r), 8'h05);
      ack_once();
      chk("single_pending_ack", pend_r, 8'h00);
      chk("single_req_ack", 8'(req_r), 8'h00);

      // round robin, pointer at 0
      do_reset();
      write_mask(8'h00);
      irq_in = 8'h81;
      tick();
      irq_in = 8'h00;
      tick();
      chk("rr_p0_first", 8'(id_r), 8'h00);
      chk("fx_p0_first", 8'(id_f), 8'h00);
      ack_once();
      chk("rr_gap", 8'(req_r), 8'h00);
      tick();
      chk("rr_p0_second_req", 8'(req_r), 8'h01);
      chk("rr_p0_second", 8'(id_r), 8'h07);
      chk("fx_p0_second", 8'(id_f), 8'h07);
      ack_once();

      // move the round-robin pointer to 1 via a single event on source 0
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      tick();
      ack_once();
      irq_in = 8'h81;
      tick();
      irq_in = 8'h00;
      tick();
      chk("rr_p1_first", 8'(id_r), 8'h07);
      chk("fx_p1_first", 8'(id_f), 8'h00);
      ack_once();
      tick();
      chk("rr_p1_second", 8'(id_r), 8'h00);
      chk("fx_p1_second", 8'(id_f), 8'h07);
      ack_once();

      // masked source stays pending until unmasked
      write_mask(8'h08);
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      tick();
      tick();
      chk("mask_pending", pend_r, 8'h08);
      chk("mask_req_held_off", 8'(req_r), 8'h00);
      write_mask(8'h00);
      chk("unmask_req_1cyc", 8'(req_r), 8'h00);
      tick();
      chk("unmask_req", 8'(req_r), 8'h01);
      chk("unmask_id", 8'(id_r), 8'h03);
      ack_once();

      // set/clear collision on source 2
      irq_in = 8'h04;
      tick();
      irq_in = 8'h00;
      tick();
      chk("coll_id", 8'(id_r), 8'h02);
      irq_in  = 8'h04;
      irq_ack = 1'b1;
      tick();
      irq_in  = 8'h00;
      irq_ack = 1'b0;
      chk("coll_pending2", pend_r & 8'h04, 8'h04);
      chk("coll_req_gap", 8'(req_r), 8'h00);
      tick();
      chk("coll_req_again", 8'(req_r), 8'h01);
      chk("coll_id_again", 8'(id_r), 8'h02);
      ack_once();

      // stability of a presented request against new edges and mask writes
      irq_in = 8'h10;
      tick();
      irq_in = 8'h00;
      tick();
      chk("stab_id_start", 8'(id_r), 8'h04);
      irq_in = 8'h01;
      write_mask(8'h10);
      chk("stab_id_a", 8'(id_r), 8'h04);
      chk("stab_req_a", 8'(req_r), 8'h01);
      tick();
      tick();
      chk("stab_id_b", 8'(id_r), 8'h04);
      chk("stab_req_b", 8'(req_r), 8'h01);
      ack_once();
      chk("stab_req_ack", 8'(req_r), 8'h00);
      tick();
      chk("stab_next_id", 8'(id_r), 8'h00);
      chk("stab_next_req", 8'(req_r), 8'h01);

      // asynchronous reset while a request is presented
      rst = 1'b1;
      #2;
      chk("arst_req", 8'(req_r), 8'h00);
      chk("arst_pending", pend_r, 8'h00);
      chk("arst_mask", mask_r, 8'hFF);
      chk("arst_fx_req", 8'(req_f), 8'h00);
      rst = 1'b0;
      model_reset();

      // random traffic
      write_mask(8'h00);
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ 8'($urandom);
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_wdata = 8'($urandom) & 8'($urandom);
         irq_ack    = ($urandom_range(0, 2) == 0);
         tick();
      end
      mask_we = 1'b0;
      irq_ack = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
